// File: rtl/ray_hit_resolver.sv
// rtl/ray_hit_resolver.sv - nearest-hit resolver walking a sync-RAM object table through a combinational tracer
// Optional hit statistics counter: define RAY_RESOLVER_STATS_EN.
module ray_hit_resolver #(
  parameter int          NUM_OBJ  = 8,
  parameter int          OBJ_AW   = 3,
  parameter int          TRC_LAT  = 1,
  parameter logic [11:0] BG_COLOR = 12'h000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ray_valid,
  output logic              ray_ready,
  input  logic [27:0]       ray_init,
  input  logic [30:0]       ray_dir,
  input  logic [OBJ_AW:0]   obj_count,
  output logic [OBJ_AW-1:0] obj_addr,
  input  logic [47:0]       obj_data,
  output logic [27:0]       trc_init,
  output logic [30:0]       trc_dir,
  output logic [47:0]       trc_obj,
  input  logic [9:0]        trc_t,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [11:0]       pix_color,
  output logic [9:0]        pix_t,
  output logic [OBJ_AW-1:0] pix_idx
`ifdef RAY_RESOLVER_STATS_EN
  ,
  output logic [15:0]       hit_cnt
`endif
);

  localparam int CW = (TRC_LAT > 1) ? $clog2(TRC_LAT) : 1;
  localparam logic [OBJ_AW:0] NUM_OBJ_W = (OBJ_AW+1)'(NUM_OBJ);
  localparam logic [9:0] T_MISS = 10'h3FF;

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, EVAL, DONE} state_t;

  state_t            r_state;
  logic              r_ray_ready;
  logic              r_pix_valid;
  logic [OBJ_AW-1:0] r_obj_addr;
  logic [OBJ_AW-1:0] r_idx;
  logic [OBJ_AW:0]   r_n;
  logic [CW-1:0]     r_cnt;
  logic [27:0]       r_trc_init;
  logic [30:0]       r_trc_dir;
  logic [47:0]       r_trc_obj;
  logic [9:0]        r_best_t;
  logic [11:0]       r_best_c;
  logic [OBJ_AW-1:0] r_best_i;

  logic [OBJ_AW:0]   w_n;
  logic              w_hit;
  logic              w_last;

  assign w_n    = (obj_count > NUM_OBJ_W) ? NUM_OBJ_W : obj_count;
  // Strict less-than keeps the earlier object on equal distances.
  assign w_hit  = (trc_t != T_MISS) && (trc_t < r_best_t);
  assign w_last = ({1'b0, r_idx} == (r_n - {{OBJ_AW{1'b0}}, 1'b1}));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_ray_ready <= 1'b0;
      r_pix_valid <= 1'b0;
      r_obj_addr  <= '0;
      r_idx       <= '0;
      r_n         <= '0;
      r_cnt       <= '0;
      r_trc_init  <= '0;
      r_trc_dir   <= '0;
      r_trc_obj   <= '0;
      r_best_t    <= T_MISS;
      r_best_c    <= BG_COLOR;
      r_best_i    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (r_ray_ready && ray_valid) begin
            r_ray_ready <= 1'b0;
            r_trc_init  <= ray_init;
            r_trc_dir   <= ray_dir;
            r_n         <= w_n;
            r_idx       <= '0;
            r_best_t    <= T_MISS;
            r_best_c    <= BG_COLOR;
            r_best_i    <= '0;
            if (w_n == '0) begin
              r_state <= DONE;
            end else begin
              r_obj_addr <= '0;
              r_state    <= FETCH;
            end
          end else begin
            r_ray_ready <= 1'b1;
          end
        end
        FETCH: r_state <= LOAD;
        LOAD: begin
          r_trc_obj <= obj_data;
          r_cnt     <= CW'(TRC_LAT - 1);
          r_state   <= EVAL;
        end
        EVAL: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            if (w_hit) begin
              r_best_t <= trc_t;
              r_best_c <= r_trc_obj[47:36];
              r_best_i <= r_idx;
            end
            if (w_last) begin
              r_state <= DONE;
            end else begin
              r_idx      <= r_idx + 1'b1;
              r_obj_addr <= r_idx + 1'b1;
              r_state    <= FETCH;
            end
          end
        end
        DONE: begin
          // One settling cycle in DONE before pix_valid rises.
          if (!r_pix_valid) begin
            r_pix_valid <= 1'b1;
          end else if (pix_ready) begin
            r_pix_valid <= 1'b0;
            r_ray_ready <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ray_ready = r_ray_ready;
  assign obj_addr  = r_obj_addr;
  assign trc_init  = r_trc_init;
  assign trc_dir   = r_trc_dir;
  assign trc_obj   = r_trc_obj;
  assign pix_valid = r_pix_valid;
  assign pix_color = r_best_c;
  assign pix_t     = r_best_t;
  assign pix_idx   = r_best_i;

`ifdef RAY_RESOLVER_STATS_EN
  logic [15:0] r_hit_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hit_cnt <= '0;
    end else if (r_pix_valid && pix_ready && (r_best_t != T_MISS) && (r_hit_cnt != 16'hFFFF)) begin
      r_hit_cnt <= r_hit_cnt + 16'd1;
    end
  end

  assign hit_cnt = r_hit_cnt;
`endif

endmodule

// File: tb/tb_ray_hit_resolver.sv
// tb/tb_ray_hit_resolver.sv - directed-vector bench for ray_hit_resolver with RAM and tracer models
module tb_ray_hit_resolver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ray_valid;
  logic        ray_ready;
  logic [27:0] ray_init;
  logic [30:0] ray_dir;
  logic [3:0]  obj_count;
  logic [2:0]  obj_addr;
  logic [47:0] obj_data;
  logic [27:0] trc_init;
  logic [30:0] trc_dir;
  logic [47:0] trc_obj;
  logic [9:0]  trc_t;
  logic        pix_valid;
  logic        pix_ready;
  logic [11:0] pix_color;
  logic [9:0]  pix_t;
  logic [2:0]  pix_idx;
`ifdef RAY_RESOLVER_STATS_EN
  logic [15:0] hit_cnt;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  logic [47:0] mem [8];
  logic [7:0]  addr_seen;
  logic        clr_seen;

  always #5 clk = ~clk;

  ray_hit_resolver dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ray_valid (ray_valid),
    .ray_ready (ray_ready),
    .ray_init  (ray_init),
    .ray_dir   (ray_dir),
    .obj_count (obj_count),
    .obj_addr  (obj_addr),
    .obj_data  (obj_data),
    .trc_init  (trc_init),
    .trc_dir   (trc_dir),
    .trc_obj   (trc_obj),
    .trc_t     (trc_t),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_color (pix_color),
    .pix_t     (pix_t),
    .pix_idx   (pix_idx)
`ifdef RAY_RESOLVER_STATS_EN
    ,
    .hit_cnt   (hit_cnt)
`endif
  );

  // Synchronous object RAM and a combinational tracer whose hit distance is stored in the object word.
  always @(posedge clk) obj_data <= mem[obj_addr];
  assign trc_t = trc_obj[9:0];

  always @(posedge clk) begin
    if (clr_seen) addr_seen <= 8'h00;
    else          addr_seen[obj_addr] <= 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_obj(input int i, input logic [11:0] c, input logic [9:0] t);
    mem[i] = {c, 8'h10, 18'h0, t};
  endtask

  task automatic issue(input logic [3:0] cnt);
    int g;
    logic [27:0] init_v;
    logic [30:0] dir_v;
    init_v    = 28'h1234560 + {24'h0, cnt};
    dir_v     = 31'h2ABCDEF0 + {27'h0, cnt};
    ray_init  = init_v;
    ray_dir   = dir_v;
    obj_count = cnt;
    ray_valid = 1'b1;
    g = 0;
    while (!ray_ready && g < 100) begin
      step();
      g++;
    end
    if (g >= 100) chk("ray_ready_timeout", 32'd0, 32'd1);
    step();
    ray_valid = 1'b0;
    chk("ready_after_accept", {31'h0, ray_ready}, 32'd0);
    chk("trc_init_latch", {4'h0, trc_init}, {4'h0, init_v});
    chk("trc_dir_latch", {1'b0, trc_dir}, {1'b0, dir_v});
  endtask

  task automatic result(input string tag, input int exp_lat, input logic [11:0] c,
                        input logic [9:0] t, input logic [2:0] i);
    int lat;
    lat = 0;
    while (!pix_valid && lat < 200) begin
      step();
      lat++;
    end
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_color"}, {20'h0, pix_color}, {20'h0, c});
    chk({tag, "_t"}, {22'h0, pix_t}, {22'h0, t});
    chk({tag, "_idx"}, {29'h0, pix_idx}, {29'h0, i});
  endtask

  task automatic take_pix();
    pix_ready = 1'b1;
    step();
    pix_ready = 1'b0;
    chk("pix_valid_drop", {31'h0, pix_valid}, 32'd0);
    chk("ready_return", {31'h0, ray_ready}, 32'd1);
  endtask

  task automatic load_t2();
    set_obj(0, 12'h111, 10'd50);
    set_obj(1, 12'h222, 10'd20);
    set_obj(2, 12'h333, 10'd80);
  endtask

`ifdef RAY_RESOLVER_STATS_EN
  logic [15:0] hc0;
`endif

  initial begin
    rst_n     = 1'b0;
    ray_valid = 1'b0;
    ray_init  = '0;
    ray_dir   = '0;
    obj_count = '0;
    pix_ready = 1'b0;
    clr_seen  = 1'b1;
    for (int k = 0; k < 8; k++) mem[k] = '0;
    step();
    step();
    chk("rst_ray_ready", {31'h0, ray_ready}, 32'd0);
    chk("rst_pix_valid", {31'h0, pix_valid}, 32'd0);
    chk("rst_pix_t", {22'h0, pix_t}, 32'h3FF);
    chk("rst_pix_color", {20'h0, pix_color}, 32'h000);
    chk("rst_obj_addr", {29'h0, obj_addr}, 32'd0);
    rst_n = 1'b1;
    step();
    chk("ready_after_reset", {31'h0, ray_ready}, 32'd1);

    // T1: empty scene
    issue(4'd0);
    result("t1", 1, 12'h000, 10'h3FF, 3'd0);
    take_pix();

    // T2: nearest of three
    load_t2();
    issue(4'd3);
    result("t2", 10, 12'h222, 10'd20, 3'd1);
    chk("t2_trc_obj_last", {16'h0, trc_obj[47:36], trc_obj[9:0]}, {16'h0, 12'h333, 10'd80});
    take_pix();

    // T3: tie keeps lower index, then all miss
    set_obj(0, 12'h111, 10'd20);
    set_obj(1, 12'h222, 10'd90);
    set_obj(2, 12'h333, 10'd20);
    issue(4'd3);
    result("t3_tie", 10, 12'h111, 10'd20, 3'd0);
    take_pix();
    set_obj(0, 12'h111, 10'h3FF);
    set_obj(1, 12'h222, 10'h3FF);
    set_obj(2, 12'h333, 10'h3FF);
    issue(4'd3);
    result("t3_miss", 10, 12'h000, 10'h3FF, 3'd0);
    take_pix();

    // T4: downstream backpressure with the next ray already waiting
    load_t2();
    issue(4'd3);
    result("t4a", 10, 12'h222, 10'd20, 3'd1);
    ray_valid = 1'b1;
    obj_count = 4'd1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t4_hold_valid", {31'h0, pix_valid}, 32'd1);
      chk("t4_hold_color", {20'h0, pix_color}, 32'h222);
      chk("t4_hold_t", {22'h0, pix_t}, 32'd20);
      chk("t4_hold_idx", {29'h0, pix_idx}, 32'd1);
      chk("t4_hold_ready", {31'h0, ray_ready}, 32'd0);
    end
    take_pix();
    issue(4'd1);
    result("t4b", 4, 12'h111, 10'd50, 3'd0);
    take_pix();

    // T5: reset in the middle of evaluation
    issue(4'd3);
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("t5_rst_ready", {31'h0, ray_ready}, 32'd0);
    chk("t5_rst_pix_valid", {31'h0, pix_valid}, 32'd0);
    chk("t5_rst_pix_t", {22'h0, pix_t}, 32'h3FF);
    chk("t5_rst_obj_addr", {29'h0, obj_addr}, 32'd0);
    chk("t5_rst_trc_obj", trc_obj[31:0], 32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("t5_ready_back", {31'h0, ray_ready}, 32'd1);
`ifdef RAY_RESOLVER_STATS_EN
    chk("t5_hit_cnt_rst", {16'h0, hit_cnt}, 32'd0);
    hc0 = hit_cnt;
`endif
    issue(4'd3);
    result("t5", 10, 12'h222, 10'd20, 3'd1);
    take_pix();

    // T6: miss ray, then count clamp to the table size
    set_obj(0, 12'h111, 10'h3FF);
    set_obj(1, 12'h222, 10'h3FF);
    set_obj(2, 12'h333, 10'h3FF);
    issue(4'd3);
    result("t6_miss", 10, 12'h000, 10'h3FF, 3'd0);
    take_pix();
    load_t2();
    issue(4'd2);
    result("t6_two", 7, 12'h222, 10'd20, 3'd1);
    take_pix();
    for (int k = 0; k < 8; k++) set_obj(k, 12'h100 + 12'(k), 10'(100 - 10 * k));
    clr_seen = 1'b1;
    step();
    clr_seen = 1'b0;
    issue(4'd15);
    result("t6_clamp", 25, 12'h107, 10'd30, 3'd7);
    chk("t6_addr_span", {24'h0, addr_seen}, 32'hFF);
    take_pix();
`ifdef RAY_RESOLVER_STATS_EN
    chk("t6_hit_cnt", {16'h0, hit_cnt - hc0}, 32'd3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
